// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core's data-access stage and the data memory responder.
// master: core side (drives request fields); slave: memory side (drives response fields).
//   req/we/addr/wdata/be : request, held by the initiator until ready
//   rdata/ready/err/busy : response, ready is a one-cycle completion pulse
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: word-aligned 32-bit
// reads/writes with byte enables, LATENCY cycles from capture to a one-cycle
// ready pulse, err flagged with ready on misaligned or out-of-range accesses.
// Ports:
//   CLK  : clock, rising edge
//   RSTn : asynchronous active-low reset (RAM contents are not reset)
//   bus  : slave side of data_mem_responder_if
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    data_mem_responder_if.slave   bus
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W   = 4;
    localparam logic [63:0] SPAN_B  = 64'(DEPTH_WORDS) * 64'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               cap_we;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;
    logic [3:0]         cap_be;

    logic [31:0]        mem [DEPTH_WORDS];

    logic [32:0]        off;
    logic               legal;
    logic [IDX_W-1:0]   idx;
    logic               mem_wr;

    // Offset from the base; bit 32 set means the address lies below BASE_ADDR.
    always_comb begin
        off    = 33'(cap_addr) - 33'(BASE_ADDR);
        legal  = (cap_addr[1:0] == 2'b00) && !off[32] && (64'(off[31:0]) < SPAN_B);
        idx    = off[IDX_W+1:2];
        mem_wr = (state == RESP) && legal && cap_we;
    end

    // Request capture, wait-state countdown and registered response.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            case (state)
                IDLE: begin
                    // busy stays high through the ready cycle and is re-armed by a held req
                    bus.busy <= bus.req;
                    if (bus.req) begin
                        cap_we    <= bus.we;
                        cap_addr  <= bus.addr;
                        cap_wdata <= bus.wdata;
                        cap_be    <= bus.be;
                        cnt       <= CNT_W'(LATENCY - 1);
                        state     <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    bus.ready <= 1'b1;
                    bus.err   <= !legal;
                    bus.rdata <= (legal && !cap_we) ? mem[idx] : 32'h0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte-masked RAM write on the RESP edge; an async reset before it cancels the write.
    always_ff @(posedge CLK) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) begin
                    mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at DEPTH_WORDS=1024, LATENCY=2, BASE_ADDR=0.
module tb_data_mem_responder;

    logic CLK;
    logic RSTn;
    int   total;
    int   bad;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (2),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction; checks latency, busy during ready and pulse width.
    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output logic [31:0] rd, output logic er);
        int lat;
        @(negedge CLK);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        bus.be    = b;
        @(posedge CLK);
        #1;
        bus.req = 1'b0;
        lat = 0;
        while (!bus.ready && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        rd = bus.rdata;
        er = bus.err;
        @(posedge CLK);
        #1;
        chk({tag, "_pulse"}, 32'(bus.ready), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          nrdy;
    int          last_rdy;

    initial begin
        total = 0;
        bad   = 0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.be    = '0;
        RSTn      = 1'b0;
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("rst_out", {bus.rdata[28:0], bus.ready, bus.err, bus.busy}, 32'h0);
            chk("rst_rdata", bus.rdata, 32'h0);
        end

        // Full store then load
        txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er);
        chk("st10_err", 32'(er), 32'd0);
        txn("ld10", 1'b0, 32'h10, 32'h0, 4'b0000, rd, er);
        chk("ld10_data", rd, 32'hDEADBEEF);
        chk("ld10_err", 32'(er), 32'd0);

        // Partial store of byte 1
        txn("pst", 1'b1, 32'h10, 32'h0000AA00, 4'b0010, rd, er);
        txn("ldp", 1'b0, 32'h10, 32'h0, 4'b1111, rd, er);
        chk("ldp_data", rd, 32'hDEADAAEF);

        // be=0 store is a no-op but still completes
        txn("nop", 1'b1, 32'h10, 32'h55555555, 4'b0000, rd, er);
        chk("nop_err", 32'(er), 32'd0);
        txn("ldn", 1'b0, 32'h10, 32'h0, 4'b0000, rd, er);
        chk("ldn_data", rd, 32'hDEADAAEF);

        // Misaligned load
        txn("mis", 1'b0, 32'h13, 32'h0, 4'b0000, rd, er);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_data", rd, 32'h0);

        // Out-of-range store must not alias onto word 0
        txn("st0", 1'b1, 32'h0, 32'h12345678, 4'b1111, rd, er);
        txn("oor", 1'b1, 32'h1000, 32'hCAFEF00D, 4'b1111, rd, er);
        chk("oor_err", 32'(er), 32'd1);
        txn("ld0", 1'b0, 32'h0, 32'h0, 4'b0000, rd, er);
        chk("ld0_data", rd, 32'h12345678);
        chk("ld0_err", 32'(er), 32'd0);

        // Last legal word
        txn("stl", 1'b1, 32'hFFC, 32'hA5A5A5A5, 4'b1111, rd, er);
        txn("ldl", 1'b0, 32'hFFC, 32'h0, 4'b0000, rd, er);
        chk("ldl_data", rd, 32'hA5A5A5A5);
        chk("ldl_err", 32'(er), 32'd0);

        // Throughput: req held for exactly 4 captures, ready every 3 cycles
        @(negedge CLK);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'h10;
        nrdy     = 0;
        last_rdy = -1;
        for (int c = 0; c < 18; c++) begin
            @(posedge CLK);
            #1;
            if (bus.ready) begin
                if (nrdy == 0) chk("thr_first", 32'(c), 32'd2);
                else           chk("thr_gap", 32'(c - last_rdy), 32'd3);
                chk("thr_data", bus.rdata, 32'hDEADAAEF);
                last_rdy = c;
                nrdy++;
                if (nrdy == 4) bus.req = 1'b0;
            end
        end
        chk("thr_count", 32'(nrdy), 32'd4);

        // Reset one cycle after capturing a store aborts it
        txn("st20", 1'b1, 32'h20, 32'h11112222, 4'b1111, rd, er);
        @(negedge CLK);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'h20;
        bus.wdata = 32'hFFFFFFFF;
        bus.be    = 4'b1111;
        @(posedge CLK);
        #1;
        bus.req = 1'b0;
        @(posedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        nrdy = 0;
        @(posedge CLK);
        #1;
        if (bus.ready) nrdy++;
        @(negedge CLK);
        RSTn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK);
            #1;
            if (bus.ready) nrdy++;
        end
        chk("arst_noready", 32'(nrdy), 32'd0);
        chk("arst_rdata", bus.rdata, 32'h0);
        txn("ld20", 1'b0, 32'h20, 32'h0, 4'b0000, rd, er);
        chk("ld20_data", rd, 32'h11112222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
